control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit directly upstream of the bus/datapath: decodes ir and drives every datapath strobe cycle by cycle (fetch T0-T2, execute T3-T7).
//  It replaces the hand-driven stimulus currently used on the datapath and runs the full instruction set to halt.
//  Moore machine: every output is a registered function of state only. Outputs change only on clk rising edges.
// PARAMETERS
//  MEM_WAIT  0  extra RAM access cycles (0..7) inserted before each MDR load from RAM and after each RAMwrite
// PORTS
//  clk                     in   1   system clock, rising edge
//  clr                     in   1   reset, asynchronous, active-low
//  ir                      in   32  IR contents; op=[31:27], Ra=[26:23], Rb=[22:19], Rc=[18:15], C=[18:0]
//  con_ff                  in   1   CON flip-flop output
//  PCout,PCin,IncPC        out  1   PC strobes
//  MARin,MDRin,MDRout      out  1   MAR/MDR strobes
//  MDRRead,RAMwrite        out  1   MDR mux select (1=RAM), RAM write enable
//  IRin,Yin,Zin            out  1   register load strobes
//  Zlowout,Zhighout        out  1   Z bus drivers
//  HIin,LOin,HIout,LOout   out  1   HI/LO strobes
//  Gra,Grb,Grc             out  1   register-field select
//  Rin_in,Rout_in,BAout    out  1   select-logic in/out/base-address strobes
//  Cout                    out  1   sign-extended C onto bus
//  CONin,con_FF_Reset      out  1   CON FF load, CON FF clear
//  r15write                out  1   load R15 from bus (jal)
//  InPortout,OutPortIn     out  1   I/O strobes
//  ALUControl              out  12  one-hot ALU op
//  run                     out  1   1 while executing; 0 in reset and HALT
// BEHAVIOUR
//  Reset (clr=0): all outputs 0 immediately, state=T0. First edge after release executes T0. run=1 from then on.
//  Reset mid-instruction aborts the instruction. Only clr leaves HALT.
//  RAMread is not driven here; it is tied high at top level.
//  ALUControl bits: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 MUL, 9 DIV, 10 NEG, 11 NOT. 0 when no ALU use.
//  Each state lasts exactly one clk. Listed strobes are high for that cycle only.
//  T0: PCout MARin IncPC Zin.
//    W (MEM_WAIT cycles): MDRRead only.
//  T1: Zlowout PCin MDRRead MDRin.
//  T2: MDRout IRin con_FF_Reset. ir is valid from T3.
//  Opcodes and execute steps:
//   00000 ld, 00001 ldi, 00010 st: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout (ldi: +Gra Rin_in, done; ld/st: +MARin)
//    ld: W; T6 MDRRead MDRin; T7 MDRout Gra Rin_in.
//    st: T6 Gra Rout_in MDRin; T7 RAMwrite (held MEM_WAIT+1 cycles).
//   00011 add, 00100 sub, 00101 shr, 00110 shl, 00111 ror, 01000 rol, 01001 and, 01010 or:
//    T3 Grb Rout_in Yin; T4 Grc Rout_in op Zin; T5 Zlowout Gra Rin_in.
//   01011 addi, 01100 andi, 01101 ori: as above but T4 uses Cout instead of Grc Rout_in.
//   01110 mul, 01111 div: T3 Gra Rout_in Yin; T4 Grb Rout_in op Zin; T5 Zlowout LOin; T6 Zhighout HIin.
//   10000 neg, 10001 not: T3 Grb Rout_in op Zin; T4 Zlowout Gra Rin_in.
//   10010 br: T3 Gra Rout_in CONin; T4 PCout Yin; T5 Cout ADD Zin; T6 Zlowout PCin only if con_ff=1, else idle cycle.
//   10011 jr: T3 Gra Rout_in PCin.   10100 jal: T3 PCout r15write; T4 Gra Rout_in PCin.
//   10101 in: T3 InPortout Gra Rin_in.   10110 out: T3 Gra Rout_in OutPortIn.
//   10111 mfhi: T3 HIout Gra Rin_in.   11000 mflo: T3 LOout Gra Rin_in.
//   11001 nop and any undefined opcode: T3 with all strobes 0.
//   11010 halt: enter HALT; all strobes 0, run=0.
//  After the last execute step the next state is T0. There are no bubbles between instructions.
//  con_ff is sampled only in the br T6 decision. Back-to-back bus drivers never overlap, because only one *out strobe is set per state.
//  Wait counter: 3 bits, reloaded to MEM_WAIT on entry to each wait. MEM_WAIT=0 inserts no W cycles.
// STRUCTURE
//  Shared header cpu_defs.vh: opcode constants, ALU one-hot constants, state encodings.
//  Single module. The decode case and the wait counter are inline. No sub-module is warranted.
// TESTING
//  1 ldi: ir=0x0900_0055 (ldi R2,0x55) -> T3 Grb+BAout+Yin; T4 Cout+Zin with ALUControl=0x001; T5 Zlowout+Gra+Rin_in; next cycle T0.
//  2 jr: ir=0x9900_0000 (jr R2) -> exactly one cycle with Gra=Rout_in=PCin=1 after T2; 4 cycles total.
//  3 br: ir=0x9100_0010 -> PCin pulses in T6 when con_ff=1; no PCin when con_ff=0; both return to T0 after 7 cycles.
//  4 MEM_WAIT=2 fetch: T0, then 2 cycles of MDRRead-only, then T1 with MDRRead+MDRin; Zlowout/PCin exactly once.
//  5 halt: ir=0xD000_0000 -> run falls after T3; all outputs 0 for 100 clks; after clr pulse low then high, T0 strobes are seen.
//  6 async reset: drop clr mid-ld at T5 -> outputs 0 before the next edge; after release, fetch restarts from T0.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU one-hot codes,
// state encoding and the registered strobe bundle.
package control_sequencer_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_OR   = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_MUL  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_NEG  = 5'd16;
    localparam logic [4:0] OP_NOT  = 5'd17;
    localparam logic [4:0] OP_BR   = 5'd18;
    localparam logic [4:0] OP_JR   = 5'd19;
    localparam logic [4:0] OP_JAL  = 5'd20;
    localparam logic [4:0] OP_IN   = 5'd21;
    localparam logic [4:0] OP_OUT  = 5'd22;
    localparam logic [4:0] OP_MFHI = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24;
    localparam logic [4:0] OP_NOP  = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd26;

    localparam logic [11:0] ALU_ADD = 12'h001;
    localparam logic [11:0] ALU_SUB = 12'h002;
    localparam logic [11:0] ALU_AND = 12'h004;
    localparam logic [11:0] ALU_OR  = 12'h008;
    localparam logic [11:0] ALU_SHR = 12'h010;
    localparam logic [11:0] ALU_SHL = 12'h020;
    localparam logic [11:0] ALU_ROR = 12'h040;
    localparam logic [11:0] ALU_ROL = 12'h080;
    localparam logic [11:0] ALU_MUL = 12'h100;
    localparam logic [11:0] ALU_DIV = 12'h200;
    localparam logic [11:0] ALU_NEG = 12'h400;
    localparam logic [11:0] ALU_NOT = 12'h800;

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
        S_WF, S_WL, S_WS, S_HALT
    } state_t;

    typedef struct packed {
        logic        pc_out, pc_in, inc_pc;
        logic        mar_in, mdr_in, mdr_out;
        logic        mdr_read, ram_write;
        logic        ir_in, y_in, z_in;
        logic        zlow_out, zhigh_out;
        logic        hi_in, lo_in, hi_out, lo_out;
        logic        gra, grb, grc;
        logic        rin, rout, ba_out;
        logic        c_out;
        logic        con_in, con_ff_reset;
        logic        r15_write;
        logic        inport_out, outport_in;
        logic [11:0] alu;
        logic        run;
    } ctrl_t;

    // ALU operation implied by an arithmetic/logic opcode; 0 for everything else.
    function automatic logic [11:0] alu_onehot(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI: return ALU_ADD;
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR,  OP_ORI:  return ALU_OR;
            OP_SHR:          return ALU_SHR;
            OP_SHL:          return ALU_SHL;
            OP_ROR:          return ALU_ROR;
            OP_ROL:          return ALU_ROL;
            OP_MUL:          return ALU_MUL;
            OP_DIV:          return ALU_DIV;
            OP_NEG:          return ALU_NEG;
            OP_NOT:          return ALU_NOT;
            default:         return 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: r_state names the step that the next clock edge executes;
// its strobes are decoded and registered on that edge, so every output is a flop.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        MDRRead,
    output logic        RAMwrite,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin_in,
    output logic        Rout_in,
    output logic        BAout,
    output logic        Cout,
    output logic        CONin,
    output logic        con_FF_Reset,
    output logic        r15write,
    output logic        InPortout,
    output logic        OutPortIn,
    output logic [11:0] ALUControl,
    output logic        run
);

    localparam logic       HAS_WAIT = (MEM_WAIT != 0);
    localparam logic [2:0] WAIT_CNT = 3'(MEM_WAIT);

    state_t      r_state;
    state_t      w_next;
    ctrl_t       r_ctrl;
    ctrl_t       w_ctrl;
    logic [2:0]  r_wcnt;
    logic [4:0]  w_op;
    logic        w_mem, w_alu3, w_imm, w_md, w_un;
    logic        w_t3_last, w_in_wait, w_enter_wait, w_wait_last;
    logic        w_unused_ir;

    assign w_op        = ir[31:27];
    assign w_unused_ir = ^ir[26:0];

    assign w_mem  = (w_op <= OP_ST);
    assign w_alu3 = (w_op >= OP_ADD)  && (w_op <= OP_OR);
    assign w_imm  = (w_op >= OP_ADDI) && (w_op <= OP_ORI);
    assign w_md   = (w_op == OP_MUL)  || (w_op == OP_DIV);
    assign w_un   = (w_op == OP_NEG)  || (w_op == OP_NOT);

    // Single-step executes: jr, in, out, mfhi, mflo, nop and undefined opcodes.
    assign w_t3_last = ((w_op >= OP_JR) && (w_op <= OP_MFLO) && (w_op != OP_JAL))
                       || (w_op == OP_NOP) || (w_op > OP_HALT);

    assign w_in_wait    = (r_state == S_WF) || (r_state == S_WL) || (r_state == S_WS);
    assign w_enter_wait = !w_in_wait && ((w_next == S_WF) || (w_next == S_WL) || (w_next == S_WS));
    assign w_wait_last  = (r_wcnt <= 3'd1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_T0:    w_next = HAS_WAIT ? S_WF : S_T1;
            S_WF:    w_next = w_wait_last ? S_T1 : S_WF;
            S_T1:    w_next = S_T2;
            S_T2:    w_next = S_T3;
            S_T3: begin
                if (w_op == OP_HALT)  w_next = S_HALT;
                else if (w_t3_last)   w_next = S_T0;
                else                  w_next = S_T4;
            end
            S_T4:    w_next = (w_un || (w_op == OP_JAL)) ? S_T0 : S_T5;
            S_T5: begin
                if ((w_op == OP_LDI) || w_alu3 || w_imm) w_next = S_T0;
                else if ((w_op == OP_LD) && HAS_WAIT)    w_next = S_WL;
                else                                     w_next = S_T6;
            end
            S_WL:    w_next = w_wait_last ? S_T6 : S_WL;
            S_T6:    w_next = ((w_op == OP_LD) || (w_op == OP_ST)) ? S_T7 : S_T0;
            S_T7:    w_next = ((w_op == OP_ST) && HAS_WAIT) ? S_WS : S_T0;
            S_WS:    w_next = w_wait_last ? S_T0 : S_WS;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_T0;
        endcase
    end

    always_comb begin
        w_ctrl     = '0;
        w_ctrl.run = 1'b1;
        case (r_state)
            S_T0: begin
                w_ctrl.pc_out = 1'b1; w_ctrl.mar_in = 1'b1;
                w_ctrl.inc_pc = 1'b1; w_ctrl.z_in   = 1'b1;
            end
            S_WF, S_WL: w_ctrl.mdr_read = 1'b1;
            S_T1: begin
                w_ctrl.zlow_out = 1'b1; w_ctrl.pc_in  = 1'b1;
                w_ctrl.mdr_read = 1'b1; w_ctrl.mdr_in = 1'b1;
            end
            S_T2: begin
                w_ctrl.mdr_out = 1'b1; w_ctrl.ir_in = 1'b1; w_ctrl.con_ff_reset = 1'b1;
            end
            S_T3: begin
                if (w_mem) begin
                    w_ctrl.grb = 1'b1; w_ctrl.ba_out = 1'b1; w_ctrl.y_in = 1'b1;
                end else if (w_alu3 || w_imm) begin
                    w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.y_in = 1'b1;
                end else if (w_md) begin
                    w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.y_in = 1'b1;
                end else if (w_un) begin
                    w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.z_in = 1'b1;
                    w_ctrl.alu = alu_onehot(w_op);
                end else begin
                    case (w_op)
                        OP_BR:   begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.con_in = 1'b1; end
                        OP_JR:   begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.pc_in = 1'b1; end
                        OP_JAL:  begin w_ctrl.pc_out = 1'b1; w_ctrl.r15_write = 1'b1; end
                        OP_IN:   begin w_ctrl.inport_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; end
                        OP_OUT:  begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.outport_in = 1'b1; end
                        OP_MFHI: begin w_ctrl.hi_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; end
                        OP_MFLO: begin w_ctrl.lo_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; end
                        default: ;
                    endcase
                end
            end
            S_T4: begin
                if (w_mem) begin
                    w_ctrl.c_out = 1'b1; w_ctrl.alu = ALU_ADD; w_ctrl.z_in = 1'b1;
                end else if (w_alu3) begin
                    w_ctrl.grc = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.z_in = 1'b1;
                    w_ctrl.alu = alu_onehot(w_op);
                end else if (w_imm) begin
                    w_ctrl.c_out = 1'b1; w_ctrl.z_in = 1'b1; w_ctrl.alu = alu_onehot(w_op);
                end else if (w_md) begin
                    w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.z_in = 1'b1;
                    w_ctrl.alu = alu_onehot(w_op);
                end else if (w_un) begin
                    w_ctrl.zlow_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                end else if (w_op == OP_BR) begin
                    w_ctrl.pc_out = 1'b1; w_ctrl.y_in = 1'b1;
                end else if (w_op == OP_JAL) begin
                    w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.pc_in = 1'b1;
                end
            end
            S_T5: begin
                if (w_op == OP_LDI || w_alu3 || w_imm) begin
                    w_ctrl.zlow_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                end else if (w_mem) begin
                    w_ctrl.zlow_out = 1'b1; w_ctrl.mar_in = 1'b1;
                end else if (w_md) begin
                    w_ctrl.zlow_out = 1'b1; w_ctrl.lo_in = 1'b1;
                end else if (w_op == OP_BR) begin
                    w_ctrl.c_out = 1'b1; w_ctrl.alu = ALU_ADD; w_ctrl.z_in = 1'b1;
                end
            end
            S_T6: begin
                if (w_op == OP_LD) begin
                    w_ctrl.mdr_read = 1'b1; w_ctrl.mdr_in = 1'b1;
                end else if (w_op == OP_ST) begin
                    w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.mdr_in = 1'b1;
                end else if (w_md) begin
                    w_ctrl.zhigh_out = 1'b1; w_ctrl.hi_in = 1'b1;
                end else if ((w_op == OP_BR) && con_ff) begin
                    w_ctrl.zlow_out = 1'b1; w_ctrl.pc_in = 1'b1;
                end
            end
            S_T7: begin
                if (w_op == OP_LD) begin
                    w_ctrl.mdr_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                end else begin
                    w_ctrl.ram_write = 1'b1;
                end
            end
            S_WS:    w_ctrl.ram_write = 1'b1;
            default: w_ctrl.run = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_T0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= w_ctrl;
        end
    end

    // Wait counter reloads on entry to any wait run and counts down to the last cycle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)              r_wcnt <= 3'd0;
        else if (w_enter_wait) r_wcnt <= WAIT_CNT;
        else if (w_in_wait)    r_wcnt <= r_wcnt - 3'd1;
    end

    assign PCout        = r_ctrl.pc_out;
    assign PCin         = r_ctrl.pc_in;
    assign IncPC        = r_ctrl.inc_pc;
    assign MARin        = r_ctrl.mar_in;
    assign MDRin        = r_ctrl.mdr_in;
    assign MDRout       = r_ctrl.mdr_out;
    assign MDRRead      = r_ctrl.mdr_read;
    assign RAMwrite     = r_ctrl.ram_write;
    assign IRin         = r_ctrl.ir_in;
    assign Yin          = r_ctrl.y_in;
    assign Zin          = r_ctrl.z_in;
    assign Zlowout      = r_ctrl.zlow_out;
    assign Zhighout     = r_ctrl.zhigh_out;
    assign HIin         = r_ctrl.hi_in;
    assign LOin         = r_ctrl.lo_in;
    assign HIout        = r_ctrl.hi_out;
    assign LOout        = r_ctrl.lo_out;
    assign Gra          = r_ctrl.gra;
    assign Grb          = r_ctrl.grb;
    assign Grc          = r_ctrl.grc;
    assign Rin_in       = r_ctrl.rin;
    assign Rout_in      = r_ctrl.rout;
    assign BAout        = r_ctrl.ba_out;
    assign Cout         = r_ctrl.c_out;
    assign CONin        = r_ctrl.con_in;
    assign con_FF_Reset = r_ctrl.con_ff_reset;
    assign r15write     = r_ctrl.r15_write;
    assign InPortout    = r_ctrl.inport_out;
    assign OutPortIn    = r_ctrl.outport_in;
    assign ALUControl   = r_ctrl.alu;
    assign run          = r_ctrl.run;

endmodule
